// File: rtl/gsm_buf_alloc_if.sv
// gsm_buf_alloc bus bundle: ingress cell handshake, bank write port,
// buffer-free return path and status. slave = allocator, master = driver.
interface gsm_buf_alloc_if #(
  parameter int MWIDTH = 4,
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 9
);
  logic              i_cell_valid;
  logic [DWIDTH-1:0] i_cell_data;
  logic [MWIDTH-1:0] i_cell_multicast;
  logic              o_cell_ready;
  logic              o_wr_en;
  logic [AWIDTH-1:0] o_wr_addr;
  logic [DWIDTH-1:0] o_wr_data;
  logic [MWIDTH-1:0] o_multicast;
  logic              i_buf_free;
  logic [AWIDTH-1:0] i_buf_free_addr;
  logic [AWIDTH:0]   o_free_count;
  logic              o_init_done;
  logic              o_drop;
  logic              o_err;

  modport slave (
    input  i_cell_valid, i_cell_data, i_cell_multicast,
    input  i_buf_free, i_buf_free_addr,
    output o_cell_ready, o_wr_en, o_wr_addr, o_wr_data,
    output o_multicast, o_free_count, o_init_done,
    output o_drop, o_err
  );

  modport master (
    output i_cell_valid, i_cell_data, i_cell_multicast,
    output i_buf_free, i_buf_free_addr,
    input  o_cell_ready, o_wr_en, o_wr_addr, o_wr_data,
    input  o_multicast, o_free_count, o_init_done,
    input  o_drop, o_err
  );
endinterface

// File: rtl/gsm_buf_alloc.sv
// Free-list owner / ingress writer for one GSM bank.
// Ports: clk, rst (async high), clr (sync), bus (gsm_buf_alloc_if.slave).
// Option GSM_ALLOC_DUP_CHECK_EN: in-use bitmap rejects duplicate frees.
module gsm_buf_alloc #(
  parameter int MWIDTH = 4,
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  gsm_buf_alloc_if.slave bus
);
  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] head_q, tail_q, init_ptr_q;
  logic [AWIDTH:0]   count_q, count_d;
  logic [AWIDTH-1:0] list_q [DEPTH];
  logic              wr_en_q, drop_q, init_done_q, err_q;
  logic [AWIDTH-1:0] wr_addr_q;
  logic [DWIDTH-1:0] wr_data_q;
  logic [MWIDTH-1:0] mc_q;

  logic run, ready, accept, alloc, mc_zero;
  logic full, dup, free_req, free_ok, free_bad;
  logic list_we;
  logic [AWIDTH-1:0] list_wd, head_addr;

  assign run       = (state_q == S_RUN);
  assign head_addr = list_q[head_q];
  // clr gate keeps a cell from being accepted into a list being wiped
  assign ready   = run & (count_q != '0) & ~clr;
  assign accept  = bus.i_cell_valid & ready;
  assign alloc   = accept & (|bus.i_cell_multicast);
  assign mc_zero = accept & ~(|bus.i_cell_multicast);
  assign full    = (count_q == (AWIDTH+1)'(DEPTH));

`ifdef GSM_ALLOC_DUP_CHECK_EN
  logic [DEPTH-1:0] inuse_q;
  assign dup = ~inuse_q[bus.i_buf_free_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inuse_q <= '0;
    end else if (clr) begin
      inuse_q <= '0;
    end else begin
      if (free_ok) inuse_q[bus.i_buf_free_addr] <= 1'b0;
      if (alloc)   inuse_q[head_addr] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign free_req = bus.i_buf_free & run & ~clr;
  assign free_ok  = free_req & ~full & ~dup;
  assign free_bad = free_req & (full | dup);

  // INIT seeds the list with 0..DEPTH-1; RUN appends returned addresses
  assign list_we = (~run & ~clr) | free_ok;
  assign list_wd = run ? bus.i_buf_free_addr : init_ptr_q;

  assign count_d = count_q + (AWIDTH+1)'(list_we)
                           - (AWIDTH+1)'(alloc);

  always_ff @(posedge clk) begin
    if (list_we) list_q[tail_q] <= list_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      head_q      <= '0;
      tail_q      <= '0;
      init_ptr_q  <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mc_q        <= '0;
      drop_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (clr) begin
      state_q     <= S_INIT;
      head_q      <= '0;
      tail_q      <= '0;
      init_ptr_q  <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mc_q        <= '0;
      drop_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tail_q  <= tail_q + AWIDTH'(list_we);
      head_q  <= head_q + AWIDTH'(alloc);
      count_q <= count_d;
      wr_en_q <= alloc;
      drop_q  <= mc_zero;
      err_q   <= err_q | free_bad;
      if (alloc) begin
        wr_addr_q <= head_addr;
        wr_data_q <= bus.i_cell_data;
        mc_q      <= bus.i_cell_multicast;
      end
      if (!run) begin
        init_ptr_q <= init_ptr_q + 1'b1;
        if (init_ptr_q == AWIDTH'(DEPTH - 1)) begin
          state_q     <= S_RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_cell_ready = ready;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_multicast  = mc_q;
  assign bus.o_free_count = count_q;
  assign bus.o_init_done  = init_done_q;
  assign bus.o_drop       = drop_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_gsm_buf_alloc.sv
// Self-checking bench for gsm_buf_alloc, AWIDTH=4 (16 cells).
// Scoreboard of expected bank writes vs. writes seen on the bus.
module tb_gsm_buf_alloc;
  localparam int MW = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int EW = AW + DW + MW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  gsm_buf_alloc_if #(.MWIDTH(MW), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  gsm_buf_alloc #(.MWIDTH(MW), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int drop_n = 0;
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] obs_q [$];
  logic [AW-1:0] free_m [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wr_en)
        obs_q.push_back({bus.o_wr_addr, bus.o_wr_data, bus.o_multicast});
      if (bus.o_drop) drop_n++;
    end
  end

  task automatic model_init();
    free_m.delete();
    for (int i = 0; i < DEPTH; i++) free_m.push_back(AW'(i));
  endtask

  task automatic free_one(input logic [AW-1:0] a);
    bus.i_buf_free = 1'b1;
    bus.i_buf_free_addr = a;
    @(posedge clk); #1;
    bus.i_buf_free = 1'b0;
  endtask

  task automatic cell_drive(input logic [MW-1:0] mc);
    bus.i_cell_valid = 1'b1;
    bus.i_cell_data = $urandom;
    bus.i_cell_multicast = mc;
    if (bus.o_cell_ready && mc != '0)
      exp_q.push_back({free_m.pop_front(), bus.i_cell_data, mc});
  endtask

  task automatic wait_init(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_init_done && n < 100);
    total++;
    if (n !== DEPTH) $display("FAIL %s_cycles: got %0d want %0d", nm, n, DEPTH);
    else passed++;
    total++;
    if (bus.o_free_count !== 5'(DEPTH))
      $display("FAIL %s_count: got %0d want %0d", nm, bus.o_free_count, DEPTH);
    else passed++;
    total++;
    if (bus.o_cell_ready !== 1'b1)
      $display("FAIL %s_ready: got %b want 1", nm, bus.o_cell_ready);
    else passed++;
    model_init();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.o_wr_en, bus.o_init_done, bus.o_err, bus.o_drop, bus.o_cell_ready} !== 5'b0)
      $display("FAIL rst_outs: got %b want 00000",
        {bus.o_wr_en, bus.o_init_done, bus.o_err, bus.o_drop, bus.o_cell_ready});
    else passed++;
    total++;
    if (bus.o_free_count !== '0)
      $display("FAIL rst_count: got %0d want 0", bus.o_free_count);
    else passed++;
    rst = 1'b0;
    wait_init("init");
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic [EW-1:0] e, o;
    for (int i = 0; i < 17; i++) begin
      if (bus.o_cell_ready) acc++;
      cell_drive(4'b0011);
      @(posedge clk); #1;
    end
    total++;
    if (bus.o_cell_ready !== 1'b0)
      $display("FAIL b2b_ready17: got %b want 0", bus.o_cell_ready);
    else passed++;
    bus.i_cell_valid = 1'b0;
    total++;
    if (acc !== DEPTH) $display("FAIL b2b_acc: got %0d want %0d", acc, DEPTH);
    else passed++;
    total++;
    if (bus.o_free_count !== '0)
      $display("FAIL b2b_count: got %0d want 0", bus.o_free_count);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL b2b_nwr: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL b2b_wr: got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_free_at_empty();
    logic [EW-1:0] e, o;
    bus.i_buf_free = 1'b1;
    bus.i_buf_free_addr = 4'd7;
    total++;
    if (bus.o_cell_ready !== 1'b0)
      $display("FAIL fe_ready_t: got %b want 0", bus.o_cell_ready);
    else passed++;
    @(posedge clk); #1;
    bus.i_buf_free = 1'b0;
    free_m.push_back(4'd7);
    total++;
    if (bus.o_cell_ready !== 1'b1)
      $display("FAIL fe_ready_t1: got %b want 1", bus.o_cell_ready);
    else passed++;
    cell_drive(4'b0101);
    @(posedge clk); #1;
    bus.i_cell_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1)
      $display("FAIL fe_nwr: got %0d want 1", obs_q.size());
    else begin
      passed++;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL fe_wr: got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_alloc_free_same();
    logic [EW-1:0] e, o;
    free_one(4'd10);
    free_m.push_back(4'd10);
    free_one(4'd11);
    free_m.push_back(4'd11);
    total++;
    if (bus.o_free_count !== 5'd2)
      $display("FAIL af_pre: got %0d want 2", bus.o_free_count);
    else passed++;
    cell_drive(4'b1000);
    bus.i_buf_free = 1'b1;
    bus.i_buf_free_addr = 4'd3;
    free_m.push_back(4'd3);
    @(posedge clk); #1;
    bus.i_buf_free = 1'b0;
    bus.i_cell_valid = 1'b0;
    total++;
    if (bus.o_free_count !== 5'd2)
      $display("FAIL af_count: got %0d want 2", bus.o_free_count);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      cell_drive(4'b0110);
      @(posedge clk); #1;
    end
    bus.i_cell_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() !== 3 || exp_q.size() !== 3)
      $display("FAIL af_nwr: got %0d want 3", obs_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL af_wr: got %h want %h", o, e);
      else passed++;
    end
    exp_q.delete();
    obs_q.delete();
    total++;
    if (bus.o_free_count !== '0)
      $display("FAIL af_end: got %0d want 0", bus.o_free_count);
    else passed++;
  endtask

  task automatic test_drop();
    int d0;
    free_one(4'd1);
    free_m.push_back(4'd1);
    d0 = drop_n;
    cell_drive(4'b0000);
    @(posedge clk); #1;
    bus.i_cell_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (drop_n - d0 !== 1) $display("FAIL drop_pulse: got %0d want 1", drop_n - d0);
    else passed++;
    total++;
    if (obs_q.size() !== 0) $display("FAIL drop_wr: got %0d want 0", obs_q.size());
    else passed++;
    total++;
    if (bus.o_free_count !== 5'd1)
      $display("FAIL drop_count: got %0d want 1", bus.o_free_count);
    else passed++;
    total++;
    if (bus.o_err !== 1'b0) $display("FAIL drop_err: got %b want 0", bus.o_err);
    else passed++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_err_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    wait_init("clr1");
    free_one(4'd5);
    total++;
    if (bus.o_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", bus.o_err);
    else passed++;
    total++;
    if (bus.o_free_count !== 5'(DEPTH))
      $display("FAIL ovf_count: got %0d want %0d", bus.o_free_count, DEPTH);
    else passed++;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if ({bus.o_err, bus.o_init_done} !== 2'b00)
      $display("FAIL clr_outs: got %b want 00", {bus.o_err, bus.o_init_done});
    else passed++;
    total++;
    if (bus.o_free_count !== '0)
      $display("FAIL clr_count: got %0d want 0", bus.o_free_count);
    else passed++;
    wait_init("clr2");
`ifdef GSM_ALLOC_DUP_CHECK_EN
    cell_drive(4'b0001);
    @(posedge clk); #1;
    bus.i_cell_valid = 1'b0;
    free_one(4'd9);
    total++;
    if (bus.o_err !== 1'b1) $display("FAIL dup_err: got %b want 1", bus.o_err);
    else passed++;
    total++;
    if (bus.o_free_count !== 5'(DEPTH - 1))
      $display("FAIL dup_count: got %0d want %0d", bus.o_free_count, DEPTH - 1);
    else passed++;
    total++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1)
      $display("FAIL dup_nwr: got %0d want 1", obs_q.size());
    else begin
      passed++;
      total++;
      if (obs_q[0] !== exp_q[0])
        $display("FAIL dup_wr: got %h want %h", obs_q[0], exp_q[0]);
      else passed++;
    end
    obs_q.delete();
    exp_q.delete();
`endif
  endtask

  initial begin
    bus.i_cell_valid = 1'b0;
    bus.i_cell_data = '0;
    bus.i_cell_multicast = '0;
    bus.i_buf_free = 1'b0;
    bus.i_buf_free_addr = '0;
    test_reset();
    test_back_to_back();
    test_free_at_empty();
    test_alloc_free_same();
    test_drop();
    test_err_clr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
